// File: rtl/adc_spi_slave.sv
// ADC128S022-style serial responder: decodes the 3-bit channel address on DIN and shifts
// {4'b0000, sample} out on DOUT. Optional abort counter port: ADC_SPI_SLAVE_ERRCNT_EN.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | CS_n high, DOUT held low, waiting for a chip-select fall
// ST_LOAD  | single cycle: strobe oSTB, capture iDATA into the shift word
// ST_SHIFT | counting SCLK rises, sampling address, driving DOUT on falls
module adc_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] RESET_CH    = 3'd0
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSCLK,
  input  logic        iCS_n,
  input  logic        iDIN,
  output logic        oDOUT,
  output logic [2:0]  oCH,
  output logic        oSTB,
  input  logic [11:0] iDATA,
  output logic        oBUSY
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
  ,
  output logic [7:0]  oERR_CNT
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  ch_q, ch_d;
  logic        dout_q, dout_d;

  logic sclk_s, cs_s, din_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic last_rise;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], iSCLK};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], iCS_n};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], iDIN};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    din_s       = din_sync_q[SYNC_STAGES-1];
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    sclk_rise   = sclk_s & ~sclk_prev_q;
    sclk_fall   = ~sclk_s & sclk_prev_q;
    cs_fall     = ~cs_s & cs_prev_q;
    cs_rise     = cs_s & ~cs_prev_q;
    last_rise   = (state_q == ST_SHIFT) && sclk_rise && (cnt_q == 4'd15);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    ch_d    = ch_q;
    dout_d  = dout_q;
    case (state_q)
      ST_IDLE: begin
        dout_d = 1'b0;
        cnt_d  = 4'd0;
        if (cs_fall) begin
          state_d = ST_LOAD;
          addr_d  = 3'd0;
        end
      end
      ST_LOAD: begin
        shift_d = {4'b0000, iDATA};
        dout_d  = 1'b0;
        state_d = ST_SHIFT;
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          addr_d  = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          cnt_d = cnt_q + 4'd1;
          case (cnt_q)
            4'd2:    addr_d[2] = din_s;
            4'd3:    addr_d[1] = din_s;
            4'd4:    addr_d[0] = din_s;
            default: ;
          endcase
          // Address commits on the 16th rise and takes effect for the next frame.
          if (cnt_q == 4'd15) begin
            ch_d    = addr_q;
            addr_d  = 3'd0;
            state_d = ST_LOAD;
          end
        end else if (sclk_fall && (cnt_q != 4'd0)) begin
          dout_d = shift_q[4'd15 - cnt_q];
        end
        if (cs_rise) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          dout_d  = 1'b0;
          addr_d  = 3'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 16'd0;
      addr_q      <= 3'd0;
      ch_q        <= RESET_CH;
      dout_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      ch_q        <= ch_d;
      dout_q      <= dout_d;
    end
  end

  assign oDOUT = dout_q;
  assign oCH   = ch_q;
  assign oSTB  = (state_q == ST_LOAD);
  assign oBUSY = (state_q != ST_IDLE);

`ifdef ADC_SPI_SLAVE_ERRCNT_EN
  // done marks a completed 16th rise, so a CS release right after a full frame is not an abort.
  logic       done_q, done_d;
  logic       abort;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    done_d = done_q;
    if ((state_q == ST_IDLE) && cs_fall) begin
      done_d = 1'b0;
    end else if ((state_q == ST_SHIFT) && sclk_rise) begin
      done_d = (cnt_q == 4'd15);
    end
    abort = cs_rise && (state_q != ST_IDLE) && !last_rise &&
            ((cnt_q != 4'd0) || !done_q);
    err_cnt_d = err_cnt_q;
    if (abort && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      done_q    <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      done_q    <= done_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign oERR_CNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_adc_spi_slave.sv
// Bench for adc_spi_slave: table of frames with hand-computed results, hand-written abort and
// reset sequences, then randomized sessions checked against a frame-level channel/data model.
module tb_adc_spi_slave;

  localparam int         SYNC   = 2;
  localparam logic [2:0] RST_CH = 3'd0;

  logic        iCLK;
  logic        iRST;
  logic        iSCLK;
  logic        iCS_n;
  logic        iDIN;
  logic [11:0] iDATA;
  logic        oDOUT;
  logic [2:0]  oCH;
  logic        oSTB;
  logic        oBUSY;
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
  logic [7:0]  oERR_CNT;
`endif

  adc_spi_slave #(
    .SYNC_STAGES(SYNC),
    .RESET_CH   (RST_CH)
  ) dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSCLK   (iSCLK),
    .iCS_n   (iCS_n),
    .iDIN    (iDIN),
    .oDOUT   (oDOUT),
    .oCH     (oCH),
    .oSTB    (oSTB),
    .iDATA   (iDATA),
    .oBUSY   (oBUSY)
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
    ,
    .oERR_CNT(oERR_CNT)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_err = 0;
  int stb_cnt = 0;

  logic [2:0] model_ch;
  int         model_err;

  always @(negedge iCLK) if (oSTB === 1'b1) stb_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Master side: SCLK idles high, falls then rises; DIN changes on falls.
  // DOUT is sampled just before each rise, giving bits 15 down to 0.
  // end_mode: 0 = keep CS low and present next_data, 1 = raise CS with the 16th rise, else no action.
  task automatic do_frame(input logic [2:0] addr, input int hp, input int n_rises,
                          input int end_mode, input logic [11:0] next_data,
                          output logic [15:0] rx, output logic [2:0] ch_mid);
    rx     = '0;
    ch_mid = '0;
    for (int j = 1; j <= n_rises; j++) begin
      iSCLK = 1'b0;
      iDIN  = (j >= 3 && j <= 5) ? addr[5-j] : 1'($urandom);
      if (j == 2) iDATA = 12'($urandom);
      wait_n(hp);
      rx[16-j] = oDOUT;
      if (j == 8) ch_mid = oCH;
      iSCLK = 1'b1;
      if (j == 16) begin
        if (end_mode == 0) iDATA = next_data;
        if (end_mode == 1) iCS_n = 1'b1;
      end
      wait_n(hp);
    end
  endtask

  task automatic frame_chk(input string tag, input logic [11:0] data, input logic [2:0] addr,
                           input int hp, input int end_mode, input logic [11:0] next_data);
    logic [15:0] rx;
    logic [2:0]  chm;
    do_frame(addr, hp, 16, end_mode, next_data, rx, chm);
    check({tag, "_dout"}, 32'(rx), 32'({4'b0000, data}));
    check({tag, "_ch_during"}, 32'(chm), 32'(model_ch));
    model_ch = addr;
    check({tag, "_ch_after"}, 32'(oCH), 32'(model_ch));
  endtask

  typedef struct {
    logic [11:0] data;
    logic [2:0]  addr;
    int          hp;
    int          end_mode;
    logic [15:0] exp_word;
    logic [2:0]  exp_ch_during;
    logic [2:0]  exp_ch_after;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rx;
    logic [2:0]  chm;
    int          s0;
    int          nf;
    logic [2:0]  ch_before;
    logic [11:0] cur_data;
    logic [11:0] nxt_data;

    iRST  = 1'b1;
    iSCLK = 1'b1;
    iCS_n = 1'b1;
    iDIN  = 1'b0;
    iDATA = 12'd0;
    model_ch  = RST_CH;
    model_err = 0;

    vecs[0] = '{12'hA5C, 3'd5, 6, 1, 16'h0A5C, 3'd0, 3'd5};
    vecs[1] = '{12'h7E1, 3'd3, 5, 0, 16'h07E1, 3'd5, 3'd3};
    vecs[2] = '{12'h123, 3'd6, 6, 2, 16'h0123, 3'd3, 3'd6};
    vecs[3] = '{12'h800, 3'd0, 4, 1, 16'h0800, 3'd6, 3'd0};
    vecs[4] = '{12'hFFF, 3'd7, 4, 2, 16'h0FFF, 3'd0, 3'd7};
    vecs[5] = '{12'h001, 3'd2, 5, 1, 16'h0001, 3'd7, 3'd2};

    wait_n(2);
    #1;
    check("rst_dout", 32'(oDOUT), 32'd0);
    check("rst_ch",   32'(oCH),   32'(RST_CH));
    check("rst_stb",  32'(oSTB),  32'd0);
    check("rst_busy", 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    iRST = 1'b0;
    wait_n(4);

    // Table: consecutive entries with end_mode 0 share one CS-low session.
    s0 = 0;
    nf = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || vecs[i-1].end_mode != 0) begin
        iDATA = vecs[i].data;
        s0    = stb_cnt;
        nf    = 0;
        iCS_n = 1'b0;
        wait_n(vecs[i].hp);
      end
      do_frame(vecs[i].addr, vecs[i].hp, 16, vecs[i].end_mode,
               (i < 5) ? vecs[i+1].data : 12'h000, rx, chm);
      nf++;
      check($sformatf("vec%0d_dout", i), 32'(rx), 32'(vecs[i].exp_word));
      check($sformatf("vec%0d_ch_during", i), 32'(chm), 32'(vecs[i].exp_ch_during));
      check($sformatf("vec%0d_ch_after", i), 32'(oCH), 32'(vecs[i].exp_ch_after));
      model_ch = vecs[i].addr;
      if (vecs[i].end_mode != 0) begin
        if (vecs[i].end_mode == 2) iCS_n = 1'b1;
        wait_n(2 * vecs[i].hp + 4);
        check($sformatf("vec%0d_busy_end", i), 32'(oBUSY), 32'd0);
        check($sformatf("vec%0d_dout_end", i), 32'(oDOUT), 32'd0);
        check($sformatf("vec%0d_stb_count", i), 32'(stb_cnt - s0),
              32'(nf + ((vecs[i].end_mode == 2) ? 1 : 0)));
      end
    end

    // Abort after 7 rises with address 110: nothing commits.
    ch_before = model_ch;
    s0 = stb_cnt;
    iCS_n = 1'b0;
    wait_n(5);
    do_frame(3'b110, 5, 7, 3, 12'h000, rx, chm);
    iCS_n = 1'b1;
    wait_n(10);
    check("abort_dout", 32'(oDOUT), 32'd0);
    check("abort_busy", 32'(oBUSY), 32'd0);
    check("abort_ch",   32'(oCH),   32'(ch_before));
    check("abort_stb",  32'(stb_cnt - s0), 32'd1);
    model_err++;
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
    check("abort_errcnt", 32'(oERR_CNT), 32'(model_err));
`endif

    // Reset at rise 9 of a frame: outputs return to reset values without a clock edge.
    iDATA = 12'h5A5;
    iCS_n = 1'b0;
    wait_n(5);
    do_frame(3'b100, 5, 9, 3, 12'h000, rx, chm);
    check("pre_rst_busy", 32'(oBUSY), 32'd1);
    iRST = 1'b1;
    #1;
    check("midrst_dout", 32'(oDOUT), 32'd0);
    check("midrst_ch",   32'(oCH),   32'(RST_CH));
    check("midrst_stb",  32'(oSTB),  32'd0);
    check("midrst_busy", 32'(oBUSY), 32'd0);
    @(negedge iCLK);
    iCS_n = 1'b1;
    iSCLK = 1'b1;
    iDIN  = 1'b0;
    wait_n(3);
    iRST = 1'b0;
    model_ch  = RST_CH;
    model_err = 0;
    wait_n(4);
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
    check("midrst_errcnt", 32'(oERR_CNT), 32'd0);
`endif

    // SCLK toggling while CS is high must not start anything.
    s0 = stb_cnt;
    for (int k = 0; k < 5; k++) begin
      iSCLK = 1'b0;
      wait_n(4);
      iSCLK = 1'b1;
      wait_n(4);
    end
    check("cs_high_sclk_stb",  32'(stb_cnt - s0), 32'd0);
    check("cs_high_sclk_busy", 32'(oBUSY), 32'd0);

    iDATA = 12'hC3E;
    s0 = stb_cnt;
    iCS_n = 1'b0;
    wait_n(5);
    frame_chk("post_rst", 12'hC3E, 3'd4, 5, 1, 12'h000);
    wait_n(12);
    check("post_rst_stb", 32'(stb_cnt - s0), 32'd1);

    // Randomized sessions against the frame-level model.
    for (int s = 0; s < 25; s++) begin
      int hp;
      hp = 4 + int'($urandom_range(0, 3));
      s0 = stb_cnt;
      if ($urandom_range(0, 5) == 0) begin
        int nr;
        nr = int'($urandom_range(1, 15));
        iCS_n = 1'b0;
        wait_n(hp);
        do_frame(3'($urandom), hp, nr, 3, 12'h000, rx, chm);
        iCS_n = 1'b1;
        wait_n(2 * hp + 4);
        model_err++;
        check($sformatf("rnd%0d_abort_ch", s), 32'(oCH), 32'(model_ch));
        check($sformatf("rnd%0d_abort_busy", s), 32'(oBUSY), 32'd0);
        check($sformatf("rnd%0d_abort_stb", s), 32'(stb_cnt - s0), 32'd1);
`ifdef ADC_SPI_SLAVE_ERRCNT_EN
        check($sformatf("rnd%0d_errcnt", s), 32'(oERR_CNT), 32'(model_err));
`endif
      end else begin
        int nfr;
        int mode;
        nfr = int'($urandom_range(1, 3));
        mode = 0;
        cur_data = 12'($urandom);
        iDATA = cur_data;
        iCS_n = 1'b0;
        wait_n(hp);
        for (int f = 0; f < nfr; f++) begin
          nxt_data = 12'($urandom);
          mode = (f == nfr - 1) ? int'($urandom_range(1, 2)) : 0;
          frame_chk($sformatf("rnd%0d_f%0d", s, f), cur_data, 3'($urandom), hp, mode, nxt_data);
          cur_data = nxt_data;
        end
        if (mode == 2) iCS_n = 1'b1;
        wait_n(2 * hp + 4);
        check($sformatf("rnd%0d_busy_end", s), 32'(oBUSY), 32'd0);
        check($sformatf("rnd%0d_stb", s), 32'(stb_cnt - s0),
              32'(nfr + ((mode == 2) ? 1 : 0)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_spi_slave.md
Name: adc_spi_slave

Overview:
Synthesizable responder for the 4-wire ADC serial link, ADC128S022-style, at the opposite end from adc_control. It decodes the 3-bit channel address on DIN and serializes a 12-bit sample on DOUT. Samples come from an upstream parallel source, such as the DDS generator or a per-channel mux. Used in FPGA-in-the-loop tests of the demodulator chain, driving adc_control without a real converter.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronizers on SCLK, CS_n and DIN (minimum 2)
RESET_CH, 0, channel reported on oCH after reset (0..7)

Ports:
iCLK  input  1  system clock; frequency must be at least 8x the SCLK frequency
iRST  input  1  asynchronous, active-high reset
iSCLK  input  1  serial clock from the master
iCS_n  input  1  active-low chip select from the master
iDIN  input  1  serial address input from the master
oDOUT  output  1  serial data output to the master
oCH  output  3  channel whose sample is being shifted in the current frame
oSTB  output  1  one-cycle pulse; iDATA is captured in this cycle
iDATA  input  12  sample for channel oCH; must be valid while oSTB=1
oBUSY  output  1  high while a frame is in progress (CS_n low)

Behaviour:
- Input path:
  - iSCLK, iCS_n and iDIN each pass through SYNC_STAGES flip-flops, then one edge-detect register.
  - Edge pulses: sclk_rise, sclk_fall, cs_fall, cs_rise.
  - Every action below happens on the iCLK edge where the relevant pulse is high.
- Reset values: oDOUT=0, oCH=RESET_CH, oSTB=0, oBUSY=0, bit counter=0, shift register=0, address register=0, synchronizers at idle (SCLK=1, CS_n=1, DIN=0).
- Frame structure: 16 SCLK cycles.
  - Frame word = {4'b0000, sample[11:0]}, sent MSB first.
  - The leading zero is driven from frame start, before the first rising edge.
- States:
  - IDLE: CS_n high, oDOUT=0, oBUSY=0.
    - On cs_fall: go to LOAD, bit counter=0, oBUSY=1.
  - LOAD: exactly one cycle, oSTB=1.
    - shift <= {4'b0000, iDATA}.
    - oDOUT <= 0.
    - Then go to SHIFT.
  - SHIFT:
    - On sclk_rise: counter k (0..15) increments.
    - DIN sampled at rises k=2, 3, 4 into addr[2], addr[1], addr[0].
    - On sclk_fall with counter 1..15: oDOUT <= frame bit (15 - counter).
    - On the 16th rise (counter 15 -> wraps to 0): oCH <= addr and address register clears. If CS_n is still low, go to LOAD (back-to-back frame). oDOUT holds its last bit until the LOAD cycle sets the leading zero.
- The addressed channel therefore applies to the next frame. The first frame after reset uses RESET_CH, or the last committed channel.
- Data latency: oDOUT changes SYNC_STAGES+1 to SYNC_STAGES+2 iCLK cycles after the physical SCLK falling edge.
- Boundaries:
  - cs_rise at any point: go to IDLE. Counter=0, oDOUT=0, oBUSY=0. An incomplete address is discarded and oCH is unchanged.
  - cs_rise in the same cycle as the 16th rise: the address commits, then go to IDLE (no LOAD).
  - An sclk_fall before any rise in a frame is ignored.
  - SCLK edges while CS_n is high are ignored.
  - cs_fall together with sclk_rise: CS takes priority; the rise is ignored.
  - iRST mid-frame: immediate return to reset values; the master's frame is lost.
- oSTB is never asserted outside LOAD. iDATA is sampled only in the LOAD cycle.

Optional Feature:
ADC_SPI_SLAVE_ERRCNT_EN:
- When defined: adds port oERR_CNT (output, 8 bits, reset 0).
  - Increments on every cs_rise that occurs with counter != 0, or with counter = 0 and no completed 16th rise in the frame (an aborted frame).
  - Saturates at 255.
- When not defined: no port and no counter logic; aborted frames are silently dropped as described.

Test Plan:
- Single frame after reset: iDATA=12'hA5C, DIN address 3'b101 -> DOUT bits 0000_1010_0101_1100; oCH=0 during the frame, oCH=5 after the 16th rise; oSTB pulses once.
- Two back-to-back frames, CS_n held low: frame 1 addresses ch 3; frame 2 iDATA=12'h123 -> exactly one oSTB at the frame boundary; oCH=3 during frame 2; frame 2 DOUT=0000_0001_0010_0011.
- CS_n deasserted after 7 SCLK rises with address 3'b110 -> oDOUT=0, oBUSY=0, oCH unchanged; with ADC_SPI_SLAVE_ERRCNT_EN, oERR_CNT=1.
- iRST pulsed at rise 9 of a frame -> all outputs return to reset values asynchronously; the next full frame works normally with oCH=RESET_CH.
- Loopback with adc_control and approximator_opt: iCLK 25 MHz, iDATA driven by a DDS sine, iCH=0 -> adc_control odata matches the iDATA captured at each oSTB with a one-frame delay; no bit errors over 1000 frames.
- SCLK glitch-free at exactly iCLK/8 -> all bits decode correctly (ratio limit check).
